// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/mask aliases, cache line/tag/index/offset typedefs,
// the cache controller state enum and the byte-enable write-merge helper.
package lc3b_types;
  localparam int C_NUM_SETS = 8;
  localparam int C_INDEX_W  = $clog2(C_NUM_SETS);
  localparam int C_TAG_W    = 12 - C_INDEX_W;

  typedef logic [15:0]          lc3b_word;
  typedef logic [1:0]           lc3b_mem_wmask;
  typedef logic [127:0]         lc3b_c_line;
  typedef logic [C_TAG_W-1:0]   lc3b_c_tag;
  typedef logic [C_INDEX_W-1:0] lc3b_c_index;
  typedef logic [3:0]           lc3b_c_offset;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} cache_state_t;

  // Byte-enable write into one 16-bit word of a line; mask[1] is the high byte.
  function automatic lc3b_c_line merge_line(input lc3b_c_line line, input logic [2:0] word,
                                            input lc3b_mem_wmask be, input lc3b_word wdata);
    lc3b_c_line r;
    r = line;
    if (be[0]) r[{word, 4'h0} +: 8] = wdata[7:0];
    if (be[1]) r[{word, 4'h8} +: 8] = wdata[15:8];
    return r;
  endfunction
endpackage

// File: rtl/cache_array.sv
// Per-set register storage: combinational read, write at posedge, optional
// synchronous clear (used for the valid and dirty bits).
module cache_array #(
  parameter int WIDTH    = 1,
  parameter int NUM_SETS = 8,
  parameter bit RESET_EN = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(NUM_SETS)-1:0] index,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata
);
  logic [WIDTH-1:0] mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (RESET_EN && reset) begin
      for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];
endmodule

// File: rtl/l1_cache_dm.sv
// Direct-mapped write-back/write-allocate L1 cache between the CPU memory port
// and a 128-bit line-wide physical memory port.
module l1_cache_dm
  import lc3b_types::*;
#(
  parameter int NUM_SETS = C_NUM_SETS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  logic [15:0]   mem_wdata,
  output logic          mem_resp,
  output logic [15:0]   mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output lc3b_c_line    pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_c_line    pmem_rdata
);
  localparam int S     = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - S;

  cache_state_t     state, next_state;
  logic [TAG_W-1:0] addr_tag, stored_tag;
  logic [S-1:0]     index;
  logic [2:0]       word;
  lc3b_c_line       stored_line, line_wdata;
  logic             stored_valid, stored_dirty;
  logic             req, is_write, hit, fill_done, wr_hit;
  logic             data_we, dirty_we;
  logic             unused_addr_bit;

  assign addr_tag        = mem_address[15:4+S];
  assign index           = mem_address[3+S:4];
  assign word            = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];

  // A combined read+write request is serviced as a write.
  assign req      = mem_read | mem_write;
  assign is_write = mem_write;
  assign hit      = stored_valid && (stored_tag == addr_tag);

  // Array writes are suppressed while reset is sampled so an abandoned fill leaves no trace.
  assign fill_done  = (state == FILL) && pmem_resp && !reset;
  assign wr_hit     = (state == CHECK) && req && hit && is_write &&
                      (mem_byte_enable != 2'b00) && !reset;
  assign data_we    = fill_done | wr_hit;
  assign dirty_we   = fill_done | wr_hit;
  assign line_wdata = fill_done ? pmem_rdata
                                : merge_line(stored_line, word, mem_byte_enable, mem_wdata);

  cache_array #(.WIDTH(128), .NUM_SETS(NUM_SETS), .RESET_EN(1'b0)) u_data (
    .clk(clk), .reset(reset), .we(data_we), .index(index),
    .wdata(line_wdata), .rdata(stored_line));

  cache_array #(.WIDTH(TAG_W), .NUM_SETS(NUM_SETS), .RESET_EN(1'b0)) u_tag (
    .clk(clk), .reset(reset), .we(fill_done), .index(index),
    .wdata(addr_tag), .rdata(stored_tag));

  cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS), .RESET_EN(1'b1)) u_valid (
    .clk(clk), .reset(reset), .we(fill_done), .index(index),
    .wdata(1'b1), .rdata(stored_valid));

  cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS), .RESET_EN(1'b1)) u_dirty (
    .clk(clk), .reset(reset), .we(dirty_we), .index(index),
    .wdata(wr_hit), .rdata(stored_dirty));

  always_ff @(posedge clk) begin
    if (reset) state <= CHECK;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CHECK:     if (req && !hit) next_state = stored_dirty ? WRITEBACK : FILL;
      WRITEBACK: if (pmem_resp) next_state = FILL;
      FILL:      if (pmem_resp) next_state = CHECK;
      default:   next_state = CHECK;
    endcase
  end

  // pmem_* decode from state alone; mem_resp/mem_rdata also depend on the live request.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (!is_write) mem_rdata = stored_line[{word, 4'h0} +: 16];
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {stored_tag, index, 4'h0};
        pmem_wdata   = stored_line;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'h0};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l1_cache_dm.sv
// Bench for l1_cache_dm: transaction-level memory/residency model, a pmem
// responder with fixed latency, and one compare process checking every cycle.
module tb_l1_cache_dm;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int checks   = 0;
  int failures = 0;
  int lat_cfg  = 5;

  // {lit_lat_v, lit_lat[7:0], lit_data_v, lit_data[15:0], wb, lat[7:0], is_read, data[15:0]}
  logic [51:0]  exp_q[$];
  logic [127:0] golden [logic [11:0]];
  logic [127:0] phys   [logic [11:0]];
  logic [8:0]   rt [8];
  bit           rv [8];
  bit           rd [8];

  logic        active = 1'b0;
  logic [11:0] cur_la = '0;
  logic [15:0] exp_wb_addr = '0;
  bit          lit_wb_v = 1'b0;
  logic [15:0] lit_wb_addr = '0;
  int          lit_wb_idx = 0;
  logic [15:0] lit_wb_word = '0;
  int          stray_req = 0;

  l1_cache_dm dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata));

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [127:0] init_line(input logic [11:0] la);
    logic [127:0] r;
    for (int w = 0; w < 8; w++) r[w*16 +: 16] = {la, 1'b0, 3'(w)};
    return r;
  endfunction

  function automatic logic [127:0] get_golden(input logic [11:0] la);
    if (golden.exists(la)) return golden[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] get_phys(input logic [11:0] la);
    if (phys.exists(la)) return phys[la];
    return init_line(la);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Physical memory: answers a held request after lat_cfg cycles; can inject a stray pulse.
  initial begin : responder
    int cnt;
    int stray_done;
    cnt = 0;
    stray_done = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (reset) begin
        cnt = 0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        pmem_resp = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= lat_cfg) begin
          pmem_resp = 1'b1;
          if (pmem_write) phys[pmem_address[15:4]] = pmem_wdata;
          else            pmem_rdata = get_phys(pmem_address[15:4]);
        end
      end
    end
  end

  // Scoreboard / compare
  initial begin : compare
    int cyc;
    int wbn;
    logic prev_rst;
    logic prev_pw;
    logic [51:0] e;
    cyc = 0;
    wbn = 0;
    prev_rst = 1'b0;
    prev_pw = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        wbn = 0;
      end else begin
        if (prev_rst) begin
          chk("rst_mem_resp", 128'(mem_resp), 128'(0));
          chk("rst_mem_rdata", 128'(mem_rdata), 128'(0));
          chk("rst_pmem_read", 128'(pmem_read), 128'(0));
          chk("rst_pmem_write", 128'(pmem_write), 128'(0));
          chk("rst_pmem_address", 128'(pmem_address), 128'(0));
          chk("rst_pmem_wdata", pmem_wdata, 128'(0));
        end
        if (active) cyc++;
        else begin
          cyc = 0;
          wbn = 0;
        end
        if (pmem_write && !prev_pw) wbn++;
        if (pmem_write) begin
          chk("wb_address", 128'(pmem_address), 128'(exp_wb_addr));
          chk("wb_data", pmem_wdata, get_golden(exp_wb_addr[15:4]));
          if (lit_wb_v) begin
            chk("wb_address_literal", 128'(pmem_address), 128'(lit_wb_addr));
            chk("wb_word_literal", 128'(pmem_wdata[lit_wb_idx*16 +: 16]), 128'(lit_wb_word));
          end
        end
        if (pmem_read) chk("fill_address", 128'(pmem_address), 128'({cur_la, 4'h0}));
        if (pmem_read && pmem_write) chk("pmem_read_and_write", 128'(1), 128'(0));
        if (mem_resp) begin
          if (!active || exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=1 expected=0");
          end else begin
            e = exp_q.pop_front();
            chk("latency", 128'(cyc), 128'(e[24:17]));
            chk("writeback_count", 128'(wbn), 128'(e[25]));
            if (e[16]) chk("rdata", 128'(mem_rdata), 128'(e[15:0]));
            if (e[42]) chk("rdata_literal", 128'(mem_rdata), 128'(e[41:26]));
            if (e[51]) chk("latency_literal", 128'(cyc), 128'(e[50:43]));
          end
          cyc = 0;
          wbn = 0;
        end else if (active && cyc == TIMEOUT) begin
          checks++;
          failures++;
          $display("FAIL timeout actual=no_resp expected=resp within %0d cycles", TIMEOUT);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      prev_rst = reset;
      prev_pw = pmem_write;
    end
  end

  // Driver: predicts the transaction from the model, then runs the handshake.
  task automatic access(input bit wr_op, input bit rd_too, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input bit ld_v, input logic [15:0] ld, input bit ll_v, input logic [7:0] ll);
    logic [2:0]   set;
    logic [8:0]   tag;
    logic [11:0]  la;
    bit           hit, wb;
    logic [7:0]   lat;
    logic [127:0] line;
    logic [15:0]  data;
    set  = addr[6:4];
    tag  = addr[15:7];
    la   = addr[15:4];
    hit  = rv[set] && (rt[set] == tag);
    wb   = !hit && rd[set];
    lat  = hit ? 8'd1 : (wb ? 8'(2*lat_cfg + 2) : 8'(lat_cfg + 2));
    exp_wb_addr = {rt[set], set, 4'h0};
    line = get_golden(la);
    data = line[addr[3:1]*16 +: 16];
    exp_q.push_back({ll_v, ll, ld_v, ld, wb, lat, !wr_op, data});
    if (wr_op) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) line[addr[3:1]*16 + b*8 +: 8] = wd[b*8 +: 8];
      golden[la] = line;
    end
    rd[set] = (hit && rd[set]) || (wr_op && be != 2'b00);
    rv[set] = 1'b1;
    rt[set] = tag;
    cur_la  = la;
    @(posedge clk); #1;
    mem_read = !wr_op || rd_too;
    mem_write = wr_op;
    mem_byte_enable = be;
    mem_address = addr;
    mem_wdata = wd;
    active = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (mem_resp) break;
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    active = 1'b0;
  endtask

  task automatic rd_lit(input logic [15:0] addr, input logic [15:0] d, input logic [7:0] l);
    access(1'b0, 1'b0, 2'b00, addr, 16'h0, 1'b1, d, 1'b1, l);
  endtask

  task automatic wr_lit(input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd,
                        input logic [7:0] l);
    access(1'b1, 1'b0, be, addr, wd, 1'b0, 16'h0, 1'b1, l);
  endtask

  initial begin : main
    logic [127:0] pre;
    for (int s = 0; s < 8; s++) begin
      rv[s] = 1'b0;
      rd[s] = 1'b0;
      rt[s] = '0;
    end
    pre = init_line(12'h123);
    pre[47:32] = 16'hBEEF;
    golden[12'h123] = pre;
    phys[12'h123] = pre;

    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address = '0;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    rd_lit(16'h1234, 16'hBEEF, 8'd7);
    rd_lit(16'h1232, 16'h1231, 8'd1);
    wr_lit(16'h1234, 2'b01, 16'hA5C3, 8'd1);
    rd_lit(16'h1234, 16'hBEC3, 8'd1);

    lit_wb_v = 1'b1; lit_wb_addr = 16'h1230; lit_wb_idx = 2; lit_wb_word = 16'hBEC3;
    rd_lit(16'h1334, 16'h1332, 8'd12);
    lit_wb_v = 1'b0;
    rd_lit(16'h1234, 16'hBEC3, 8'd7);

    access(1'b1, 1'b1, 2'b11, 16'h1232, 16'h7777, 1'b0, 16'h0, 1'b1, 8'd1);
    stray_req++;
    repeat (3) @(posedge clk);
    rd_lit(16'h1232, 16'h7777, 8'd1);

    rd_lit(16'hFFFE, 16'hFFF7, 8'd7);
    wr_lit(16'hFFFE, 2'b00, 16'h0000, 8'd1);
    rd_lit(16'h0070, 16'h0070, 8'd7);
    wr_lit(16'hFFF2, 2'b10, 16'hAB00, 8'd7);
    rd_lit(16'hFFF2, 16'hABF1, 8'd1);
    lit_wb_v = 1'b1; lit_wb_addr = 16'hFFF0; lit_wb_idx = 1; lit_wb_word = 16'hABF1;
    rd_lit(16'h0070, 16'h0070, 8'd12);
    lit_wb_v = 1'b0;
    wr_lit(16'h1230, 2'b11, 16'hCAFE, 8'd1);

    // Reset in the middle of a fill: dirty contents are lost, nothing is written back.
    lat_cfg = 20;
    @(posedge clk); #1;
    cur_la = 12'h200;
    mem_address = 16'h2000;
    mem_read = 1'b1;
    active = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    mem_read = 1'b0;
    active = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (rv[s] && rd[s]) golden[{rt[s], 3'(s)}] = get_phys({rt[s], 3'(s)});
      rv[s] = 1'b0;
      rd[s] = 1'b0;
    end
    lat_cfg = 5;
    repeat (2) @(posedge clk);
    stray_req++;
    repeat (3) @(posedge clk);
    rd_lit(16'h1234, 16'hBEC3, 8'd7);
    rd_lit(16'h1232, 16'h1231, 8'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
